// File: rtl/clint_if.sv
// clint_if: EX-stage trap inputs, CSR state and the CLINT write/redirect outputs.
interface clint_if #(parameter int CSR_ADDRESS_WIDTH = 12);
    logic                         ex_valid;
    logic [31:0]                  ex_pc;
    logic                         inst_ecall;
    logic                         inst_ebreak;
    logic                         inst_mret;
    logic                         ex_csr_we;
    logic                         irq_timer;
    logic                         irq_ext;
    logic [31:0]                  csr_mtvec;
    logic [31:0]                  csr_mepc;
    logic [31:0]                  csr_mstatus;
    logic                         csr_we_clint;
    logic [CSR_ADDRESS_WIDTH-1:0] csr_waddr_clint;
    logic [31:0]                  csr_wdata_clint;
    logic                         stall_o;
    logic                         jump_en;
    logic [31:0]                  jump_addr;
    modport master (
        input  ex_valid, ex_pc, inst_ecall, inst_ebreak, inst_mret, ex_csr_we,
               irq_timer, irq_ext, csr_mtvec, csr_mepc, csr_mstatus,
        output csr_we_clint, csr_waddr_clint, csr_wdata_clint, stall_o, jump_en, jump_addr
    );
    modport slave (
        output ex_valid, ex_pc, inst_ecall, inst_ebreak, inst_mret, ex_csr_we,
               irq_timer, irq_ext, csr_mtvec, csr_mepc, csr_mstatus,
        input  csr_we_clint, csr_waddr_clint, csr_wdata_clint, stall_o, jump_en, jump_addr
    );
endinterface

// File: rtl/clint.sv
// clint: machine-mode trap entry/return sequencer writing mepc/mcause/mstatus one per cycle.
module clint #(
    parameter bit TIMER_IRQ_EN      = 1'b1,
    parameter bit EXT_IRQ_EN        = 1'b1,
    parameter int CSR_ADDRESS_WIDTH = 12
) (
    input logic     clk,
    input logic     rst,
    clint_if.master bus
);
    localparam logic [CSR_ADDRESS_WIDTH-1:0] CSR_MSTATUS = CSR_ADDRESS_WIDTH'('h300);
    localparam logic [CSR_ADDRESS_WIDTH-1:0] CSR_MEPC    = CSR_ADDRESS_WIDTH'('h341);
    localparam logic [CSR_ADDRESS_WIDTH-1:0] CSR_MCAUSE  = CSR_ADDRESS_WIDTH'('h342);
    typedef enum logic [2:0] {IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, MRET} state_t;
    state_t      state, next;
    logic [31:0] cause, pc, mstatus, cause_d, entry_ms, ret_ms;
    logic        idle, irq_e, irq_t, irq_ok, take_mret, take_trap;
    always_comb begin
        idle      = state == IDLE;
        irq_e     = EXT_IRQ_EN & bus.irq_ext;
        irq_t     = TIMER_IRQ_EN & bus.irq_timer;
        irq_ok    = bus.csr_mstatus[3] & ~bus.ex_csr_we & (irq_e | irq_t);
        take_mret = idle & bus.ex_valid & bus.inst_mret;
        take_trap = idle & bus.ex_valid & ~bus.inst_mret & (bus.inst_ecall | bus.inst_ebreak | irq_ok);
        cause_d   = bus.inst_ecall ? 32'd11 : bus.inst_ebreak ? 32'd3 :
                    irq_e ? 32'h8000_000B : 32'h8000_0007;
        next      = idle ? (take_mret ? MRET : take_trap ? W_MEPC : IDLE) :
                    state == W_MEPC ? W_MCAUSE : state == W_MCAUSE ? W_MSTATUS : IDLE;
        entry_ms  = {mstatus[31:13], 2'b11, mstatus[10:8], mstatus[3], mstatus[6:4], 1'b0, mstatus[2:0]};
        ret_ms    = {bus.csr_mstatus[31:13], 2'b00, bus.csr_mstatus[10:8], 1'b1,
                     bus.csr_mstatus[6:4], bus.csr_mstatus[7], bus.csr_mstatus[2:0]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cause   <= '0;
            pc      <= '0;
            mstatus <= '0;
        end else begin
            state <= next;
            if (take_trap) begin
                cause   <= cause_d;
                pc      <= bus.ex_pc;
                mstatus <= bus.csr_mstatus;
            end
        end
    end
    // mret reads live mstatus/mepc so any earlier mepc write is already visible
    always_comb begin
        bus.csr_we_clint    = !idle;
        bus.csr_waddr_clint = state == W_MEPC ? CSR_MEPC : state == W_MCAUSE ? CSR_MCAUSE :
                              (state == W_MSTATUS || state == MRET) ? CSR_MSTATUS : '0;
        bus.csr_wdata_clint = state == W_MEPC ? pc : state == W_MCAUSE ? cause :
                              state == W_MSTATUS ? entry_ms : state == MRET ? ret_ms : '0;
        bus.jump_en         = state == W_MSTATUS || state == MRET;
        bus.jump_addr       = state == W_MSTATUS ? (bus.csr_mtvec & ~32'd3) :
                              state == MRET ? bus.csr_mepc : '0;
        bus.stall_o         = !idle | take_mret | take_trap;
    end
endmodule
